pipe_stage_reg: RTL

- Parametrised pipeline stage register: successor to the fixed two-word, always-loading stage registers between IF/ID/EX/MEM/WB.
- Carries NUM_CH channels of WIDTH bits with a valid/ready handshake, a two-entry skid buffer and a synchronous flush.
- Lets hazard and branch logic stall or squash any stage without combinational ready paths crossing stage boundaries.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_data_slot.sv | 14 +
 rtl/pipe_stage_reg.sv | 54 +++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and channel offset helper for the pipeline stage register
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b10;
  function automatic int unsigned ch_slice(input int unsigned k, input int unsigned width = 32);
    return k * width;
  endfunction
endpackage

// File: rtl/pipe_data_slot.sv
// pipe_data_slot: load-enable data register with synchronous clear
module pipe_data_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with two-entry skid and flush; PIPE_STAGE_STALL_CNT_EN adds stall_cnt
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]        stall_cnt
);
  localparam int DW = NUM_CH * WIDTH;
  logic [1:0]    state, state_nx;
  logic [DW-1:0] skid, main_d;
  logic          in_fire, out_fire, main_ld, skid_ld;
  assign in_ready  = (state != ST_SKID) & ~rst;
  assign out_valid = state != ST_EMPTY;
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    state_nx = flush ? ST_EMPTY :
               state == ST_EMPTY ? (in_fire ? ST_FULL : ST_EMPTY) :
               state == ST_FULL  ? (in_fire & ~out_fire ? ST_SKID :
                                    out_fire & ~in_fire ? ST_EMPTY : ST_FULL) :
               state == ST_SKID  ? (out_fire ? ST_FULL : ST_SKID) : ST_EMPTY;
    // a flush drops any same-cycle capture into either slot
    main_ld  = ~flush & ((state == ST_EMPTY & in_fire) |
                         (state == ST_FULL & in_fire & out_fire) |
                         (state == ST_SKID & out_fire));
    skid_ld  = ~flush & (state == ST_FULL) & in_fire & ~out_fire;
    main_d   = (state == ST_SKID) ? skid : in_data;
  end
  always_ff @(posedge clk)
    state <= rst ? ST_EMPTY : state_nx;
  pipe_data_slot #(.WIDTH(DW)) u_main (.clk(clk), .clr(rst), .ld(main_ld), .d(main_d),  .q(out_data));
  pipe_data_slot #(.WIDTH(DW)) u_skid (.clk(clk), .clr(rst), .ld(skid_ld), .d(in_data), .q(skid));
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (out_valid & ~out_ready & ~&cnt) cnt <= cnt + 1'b1;
  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule
